// File: rtl/auto_throttle_sequencer_pkg.sv
// Shared definitions for the auto throttle sequencer. This package holds the
// receiver select codes, the sequencer state encoding (also decoded by the
// flight_mode debug logic), counter widths and small throttle helpers.
package auto_throttle_sequencer_pkg;

    localparam int REC_DATA_SEL_BIT_WIDTH = 3;
    localparam int MOTOR_RATE_BIT_WIDTH   = 8;

    // The ramp step period fits 15 bits; the rise hold needs 21 bits. The
    // single timer instance is sized for the wider of the two.
    localparam int STEP_CNT_W = 15;
    localparam int HOLD_CNT_W = 21;

    typedef enum logic [REC_DATA_SEL_BIT_WIDTH-1:0] {
        REC_SEL_OFF           = 3'd0,
        REC_SEL_PASS_THROUGH  = 3'd1,
        REC_SEL_AUTO_TAKE_OFF = 3'd2,
        REC_SEL_AUTO_LAND     = 3'd3,
        REC_SEL_HOVER         = 3'd4
    } rec_sel_e;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_PASS      = 3'd1,
        ST_RAMP_UP   = 3'd2,
        ST_RISE_HOLD = 3'd3,
        ST_HOVER     = 3'd4,
        ST_RAMP_DOWN = 3'd5,
        ST_LANDED    = 3'd6
    } seq_state_e;

    // Unused codes 5-7 fall back to landing, the safest interpretation.
    function automatic rec_sel_e decode_sel(input logic [REC_DATA_SEL_BIT_WIDTH-1:0] raw);
        if (raw > 3'd4) begin
            return REC_SEL_AUTO_LAND;
        end
        return rec_sel_e'(raw);
    endfunction

    // 8-bit add computed in 9 bits and saturated at 255.
    function automatic logic [MOTOR_RATE_BIT_WIDTH-1:0] sat_add_u8(
        input logic [MOTOR_RATE_BIT_WIDTH-1:0] a,
        input logic [MOTOR_RATE_BIT_WIDTH-1:0] b
    );
        logic [MOTOR_RATE_BIT_WIDTH:0] sum;
        sum = {1'b0, a} + {1'b0, b};
        return sum[MOTOR_RATE_BIT_WIDTH] ? 8'hFF : sum[MOTOR_RATE_BIT_WIDTH-1:0];
    endfunction

    // Lift a value to the idle floor so no auto state starts below it.
    function automatic logic [MOTOR_RATE_BIT_WIDTH-1:0] floor_thr(
        input logic [MOTOR_RATE_BIT_WIDTH-1:0] val,
        input logic [MOTOR_RATE_BIT_WIDTH-1:0] floor_val
    );
        return (val < floor_val) ? floor_val : val;
    endfunction

endpackage

// File: rtl/auto_throttle_sequencer_step_timer.sv
// Loadable periodic down-counter. After a load of N-1 it raises tick_o for
// one cycle every N cycles, reloading itself from the last loaded value.
module auto_throttle_sequencer_step_timer #(
    parameter int W = 21
) (
    input  logic         clk_i,
    input  logic         reset_i,
    input  logic         load_i,
    input  logic [W-1:0] load_val_i,
    output logic         tick_o
);

    logic [W-1:0] count_q;
    logic [W-1:0] count_d;
    logic [W-1:0] reload_q;
    logic [W-1:0] reload_d;

    assign tick_o = (count_q == '0);

    // Next count: load wins, otherwise reload on tick or count down.
    always_comb begin
        // NOTE: every signal gets a default first so no path infers a latch.
        count_d  = count_q;
        reload_d = reload_q;
        if (load_i) begin
            count_d  = load_val_i;
            reload_d = load_val_i;
        end else if (tick_o) begin
            count_d = reload_q;
        end else begin
            count_d = count_q - W'(1);
        end
    end

    // Counter registers with synchronous reset.
    always_ff @(posedge clk_i) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples pre-edge values regardless of statement order.
        if (reset_i) begin
            count_q  <= '0;
            reload_q <= '0;
        end else begin
            count_q  <= count_d;
            reload_q <= reload_d;
        end
    end

endmodule

// File: rtl/auto_throttle_sequencer.sv
// Throttle command sequencer for the autonomous flight phases: ramped
// take-off, timed rise, hover hold, ramped landing and pilot pass-through.
// The new select takes effect on the next edge and ramps resume from the
// present throttle so transitions are bumpless.
module auto_throttle_sequencer
    import auto_throttle_sequencer_pkg::*;
#(
    parameter logic [7:0]  THR_MIN         = 8'd10,
    parameter logic [7:0]  HOVER_THR       = 8'd120,
    parameter logic [7:0]  RISE_BOOST      = 8'd8,
    parameter int unsigned TAKEOFF_STEP_US = 10000,
    parameter int unsigned LAND_STEP_US    = 20000,
    parameter int unsigned RISE_HOLD_US    = 2000000
) (
    input  logic                                us_clk,
    input  logic                                reset,
    input  logic [REC_DATA_SEL_BIT_WIDTH-1:0]   rec_data_sel,
    input  logic [MOTOR_RATE_BIT_WIDTH-1:0]     curr_throttle_val,
    output logic [MOTOR_RATE_BIT_WIDTH-1:0]     throttle_out,
    output logic [2:0]                          seq_state,
    output logic                                busy,
    output logic                                takeoff_done,
    output logic                                land_done
);

    // Timer loads are period-1 because the timer ticks when it reaches zero.
    localparam logic [STEP_CNT_W-1:0] TAKEOFF_LOAD = STEP_CNT_W'(TAKEOFF_STEP_US - 1);
    localparam logic [STEP_CNT_W-1:0] LAND_LOAD    = STEP_CNT_W'(LAND_STEP_US - 1);
    localparam logic [HOLD_CNT_W-1:0] RISE_LOAD    = HOLD_CNT_W'(RISE_HOLD_US - 1);
    localparam logic [MOTOR_RATE_BIT_WIDTH-1:0] RISE_THR = sat_add_u8(HOVER_THR, RISE_BOOST);

    seq_state_e                       state_q;
    seq_state_e                       state_d;
    logic [MOTOR_RATE_BIT_WIDTH-1:0]  throttle_q;
    logic [MOTOR_RATE_BIT_WIDTH-1:0]  throttle_d;
    logic                             busy_q;
    logic                             takeoff_done_q;
    logic                             land_done_q;

    rec_sel_e                         sel;
    logic                             timer_load;
    logic [HOLD_CNT_W-1:0]            timer_load_val;
    logic                             timer_tick;

    assign sel = decode_sel(rec_data_sel);

    // Next state and throttle from the select and the current phase.
    always_comb begin
        state_d    = state_q;
        throttle_d = throttle_q;
        case (sel)
            REC_SEL_OFF: begin
                state_d    = ST_IDLE;
                throttle_d = THR_MIN;
            end
            REC_SEL_PASS_THROUGH: begin
                state_d    = ST_PASS;
                throttle_d = curr_throttle_val;
            end
            REC_SEL_AUTO_TAKE_OFF: begin
                case (state_q)
                    ST_RAMP_UP: begin
                        if (throttle_q >= HOVER_THR) begin
                            state_d    = ST_RISE_HOLD;
                            throttle_d = RISE_THR;
                        end else if (timer_tick) begin
                            throttle_d = throttle_q + 8'd1;
                        end
                    end
                    ST_RISE_HOLD: begin
                        if (timer_tick) begin
                            state_d    = ST_HOVER;
                            throttle_d = HOVER_THR;
                        end else begin
                            throttle_d = RISE_THR;
                        end
                    end
                    ST_HOVER: begin
                        throttle_d = HOVER_THR;
                    end
                    default: begin
                        state_d    = ST_RAMP_UP;
                        throttle_d = floor_thr(throttle_q, THR_MIN);
                    end
                endcase
            end
            REC_SEL_HOVER: begin
                state_d    = ST_HOVER;
                throttle_d = HOVER_THR;
            end
            default: begin
                // Auto land, including the unused select codes.
                case (state_q)
                    ST_RAMP_DOWN: begin
                        if (throttle_q <= THR_MIN) begin
                            state_d    = ST_LANDED;
                            throttle_d = THR_MIN;
                        end else if (timer_tick) begin
                            throttle_d = throttle_q - 8'd1;
                        end
                    end
                    ST_LANDED: begin
                        throttle_d = THR_MIN;
                    end
                    default: begin
                        state_d    = ST_RAMP_DOWN;
                        throttle_d = floor_thr(throttle_q, THR_MIN);
                    end
                endcase
            end
        endcase
    end

    // Restart the timer on every state entry with the period of the new phase.
    always_comb begin
        timer_load     = (state_d != state_q);
        timer_load_val = '0;
        case (state_d)
            ST_RAMP_UP:   timer_load_val = {{(HOLD_CNT_W-STEP_CNT_W){1'b0}}, TAKEOFF_LOAD};
            ST_RAMP_DOWN: timer_load_val = {{(HOLD_CNT_W-STEP_CNT_W){1'b0}}, LAND_LOAD};
            ST_RISE_HOLD: timer_load_val = RISE_LOAD;
            default:      timer_load_val = '0;
        endcase
    end

    auto_throttle_sequencer_step_timer #(
        .W (HOLD_CNT_W)
    ) u_step_timer (
        .clk_i      (us_clk),
        .reset_i    (reset),
        .load_i     (timer_load),
        .load_val_i (timer_load_val),
        .tick_o     (timer_tick)
    );

    // Sequencer state and registered outputs.
    always_ff @(posedge us_clk) begin
        if (reset) begin
            state_q        <= ST_IDLE;
            throttle_q     <= THR_MIN;
            busy_q         <= 1'b0;
            takeoff_done_q <= 1'b0;
            land_done_q    <= 1'b0;
        end else begin
            state_q        <= state_d;
            throttle_q     <= throttle_d;
            busy_q         <= (state_d == ST_RAMP_UP) || (state_d == ST_RISE_HOLD) ||
                              (state_d == ST_RAMP_DOWN);
            takeoff_done_q <= (state_q == ST_RISE_HOLD) && (state_d == ST_HOVER);
            land_done_q    <= (state_q == ST_RAMP_DOWN) && (state_d == ST_LANDED);
        end
    end

    assign throttle_out = throttle_q;
    assign seq_state    = state_q;
    assign busy         = busy_q;
    assign takeoff_done = takeoff_done_q;
    assign land_done    = land_done_q;

endmodule

// File: tb/tb_auto_throttle_sequencer.sv
// Self-checking bench: directed phase checks with literal expectations, a
// saturation check on a second instance, then randomized select sequences
// compared every cycle against an elapsed-time model of the sequencer.
module tb_auto_throttle_sequencer;

    localparam int P_THR_MIN = 10;
    localparam int P_HOVER   = 20;
    localparam int P_BOOST   = 8;
    localparam int P_TS      = 4;
    localparam int P_LS      = 8;
    localparam int P_RH      = 20;
    localparam int P_RISE    = (P_HOVER + P_BOOST > 255) ? 255 : P_HOVER + P_BOOST;

    logic       clk = 1'b0;
    logic       reset;
    logic [2:0] rec_data_sel;
    logic [7:0] curr_throttle_val;
    logic [7:0] throttle_out;
    logic [2:0] seq_state;
    logic       busy;
    logic       takeoff_done;
    logic       land_done;

    logic       reset2;
    logic [2:0] sel2;
    logic [7:0] curr2;
    logic [7:0] thr2;
    logic [2:0] state2;
    logic       busy2;
    logic       td2;
    logic       ld2;

    int tests = 0;
    int fails = 0;
    bit cmp_en = 1'b0;

    always #5 clk = ~clk;

    auto_throttle_sequencer #(
        .THR_MIN(8'd10), .HOVER_THR(8'd20), .RISE_BOOST(8'd8),
        .TAKEOFF_STEP_US(4), .LAND_STEP_US(8), .RISE_HOLD_US(20)
    ) dut (
        .us_clk(clk), .reset(reset), .rec_data_sel(rec_data_sel),
        .curr_throttle_val(curr_throttle_val), .throttle_out(throttle_out),
        .seq_state(seq_state), .busy(busy), .takeoff_done(takeoff_done),
        .land_done(land_done)
    );

    auto_throttle_sequencer #(
        .THR_MIN(8'd10), .HOVER_THR(8'd250), .RISE_BOOST(8'd10),
        .TAKEOFF_STEP_US(1), .LAND_STEP_US(1), .RISE_HOLD_US(3)
    ) dut_sat (
        .us_clk(clk), .reset(reset2), .rec_data_sel(sel2),
        .curr_throttle_val(curr2), .throttle_out(thr2),
        .seq_state(state2), .busy(busy2), .takeoff_done(td2),
        .land_done(ld2)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s at %0t: got %0d, expected %0d", name, $time, act, exp);
        end
    endtask

    task automatic tick_n(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wait_for_thr(input int val, input int budget);
        int n = 0;
        while (throttle_out !== 8'(val) && n < budget) begin
            @(negedge clk);
            n++;
        end
        check("wait_throttle", 32'(throttle_out), val);
    endtask

    // Reference model: phase plus cycles elapsed since entering it.
    int m_state = 0;
    int m_thr   = P_THR_MIN;
    int m_age   = 0;
    int m_busy  = 0;
    int m_td    = 0;
    int m_ld    = 0;

    always @(posedge clk) begin
        int sel;
        int ns;
        int nt;
        int age1;
        sel = (int'(rec_data_sel) > 4) ? 3 : int'(rec_data_sel);
        if (reset) begin
            m_state = 0; m_thr = P_THR_MIN; m_age = 0;
            m_busy = 0; m_td = 0; m_ld = 0;
        end else begin
            age1 = m_age + 1;
            ns   = m_state;
            nt   = m_thr;
            case (sel)
                0: begin ns = 0; nt = P_THR_MIN; end
                1: begin ns = 1; nt = int'(curr_throttle_val); end
                2: begin
                    if (m_state == 2) begin
                        if (m_thr >= P_HOVER) begin ns = 3; nt = P_RISE; end
                        else if (age1 % P_TS == 0) nt = m_thr + 1;
                    end else if (m_state == 3) begin
                        if (age1 == P_RH) begin ns = 4; nt = P_HOVER; end
                    end else if (m_state == 4) begin
                        nt = P_HOVER;
                    end else begin
                        ns = 2;
                        nt = (m_thr < P_THR_MIN) ? P_THR_MIN : m_thr;
                    end
                end
                4: begin ns = 4; nt = P_HOVER; end
                default: begin
                    if (m_state == 5) begin
                        if (m_thr <= P_THR_MIN) begin ns = 6; nt = P_THR_MIN; end
                        else if (age1 % P_LS == 0) nt = m_thr - 1;
                    end else if (m_state == 6) begin
                        nt = P_THR_MIN;
                    end else begin
                        ns = 5;
                        nt = (m_thr < P_THR_MIN) ? P_THR_MIN : m_thr;
                    end
                end
            endcase
            m_td    = (m_state == 3 && ns == 4) ? 1 : 0;
            m_ld    = (m_state == 5 && ns == 6) ? 1 : 0;
            m_busy  = (ns == 2 || ns == 3 || ns == 5) ? 1 : 0;
            m_age   = (ns == m_state) ? age1 : 0;
            m_state = ns;
            m_thr   = nt;
        end
    end

    // Every-cycle comparison of the main instance against the model.
    always @(negedge clk) begin
        if (cmp_en) begin
            check("model_throttle", 32'(throttle_out), m_thr);
            check("model_state", 32'(seq_state), m_state);
            check("model_busy", 32'(busy), m_busy);
            check("model_takeoff_done", 32'(takeoff_done), m_td);
            check("model_land_done", 32'(land_done), m_ld);
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1; rec_data_sel = 3'd0; curr_throttle_val = 8'd0;
        reset2 = 1'b1; sel2 = 3'd0; curr2 = 8'd0;
        tick_n(2);
        cmp_en = 1'b1;

        // Saturation: hover 250 plus boost 10 clips to 255 in rise hold.
        reset2 = 1'b0; sel2 = 3'd1; curr2 = 8'd250;
        tick_n(1);
        check("sat_pass", 32'(thr2), 250);
        sel2 = 3'd2;
        tick_n(1);
        check("sat_ramp_state", 32'(state2), 2);
        tick_n(1);
        check("sat_rise_thr", 32'(thr2), 255);
        check("sat_rise_state", 32'(state2), 3);
        tick_n(3);
        check("sat_hover_thr", 32'(thr2), 250);
        check("sat_takeoff_done", 32'(td2), 1);

        // Reset state.
        check("reset_throttle", 32'(throttle_out), 10);
        check("reset_state", 32'(seq_state), 0);
        check("reset_busy", 32'(busy), 0);
        reset = 1'b0;
        tick_n(1);

        // Take-off: 10 -> 20 stepping every 4 cycles, 28 for 20, then 20.
        rec_data_sel = 3'd2;
        tick_n(1);
        check("to_entry_state", 32'(seq_state), 2);
        check("to_entry_thr", 32'(throttle_out), 10);
        check("to_entry_busy", 32'(busy), 1);
        tick_n(3);
        check("to_before_step", 32'(throttle_out), 10);
        tick_n(1);
        check("to_first_step", 32'(throttle_out), 11);
        tick_n(36);
        check("to_reach_hover", 32'(throttle_out), 20);
        check("to_reach_state", 32'(seq_state), 2);
        tick_n(1);
        check("to_rise_thr", 32'(throttle_out), 28);
        check("to_rise_state", 32'(seq_state), 3);
        tick_n(19);
        check("to_rise_last", 32'(throttle_out), 28);
        tick_n(1);
        check("to_hover_state", 32'(seq_state), 4);
        check("to_hover_thr", 32'(throttle_out), 20);
        check("to_done_pulse", 32'(takeoff_done), 1);
        check("to_hover_busy", 32'(busy), 0);
        tick_n(1);
        check("to_done_cleared", 32'(takeoff_done), 0);

        // Landing: 20 -> 10 stepping every 8 cycles, then LANDED.
        rec_data_sel = 3'd3;
        tick_n(1);
        check("ld_entry_state", 32'(seq_state), 5);
        check("ld_entry_thr", 32'(throttle_out), 20);
        tick_n(8);
        check("ld_first_step", 32'(throttle_out), 19);
        tick_n(72);
        check("ld_floor", 32'(throttle_out), 10);
        tick_n(1);
        check("ld_landed_state", 32'(seq_state), 6);
        check("ld_done_pulse", 32'(land_done), 1);
        tick_n(1);
        check("ld_no_repulse", 32'(land_done), 0);
        check("ld_hold_floor", 32'(throttle_out), 10);

        // Bumpless switch from ramp up to ramp down, then pass-through.
        rec_data_sel = 3'd2;
        wait_for_thr(15, 40);
        rec_data_sel = 3'd3;
        tick_n(1);
        check("bl_down_entry", 32'(throttle_out), 15);
        check("bl_down_state", 32'(seq_state), 5);
        tick_n(8);
        check("bl_down_step", 32'(throttle_out), 14);
        rec_data_sel = 3'd1; curr_throttle_val = 8'd200;
        tick_n(1);
        check("bl_pass_thr", 32'(throttle_out), 200);
        check("bl_pass_state", 32'(seq_state), 1);

        // Illegal select behaves as auto land.
        rec_data_sel = 3'd4;
        tick_n(1);
        check("il_hover_thr", 32'(throttle_out), 20);
        rec_data_sel = 3'd6;
        tick_n(1);
        check("il_state", 32'(seq_state), 5);
        tick_n(8);
        check("il_step", 32'(throttle_out), 19);

        // Reset mid ramp, and reset on the cycle a done pulse was due.
        rec_data_sel = 3'd0;
        tick_n(1);
        rec_data_sel = 3'd2;
        tick_n(10);
        reset = 1'b1;
        tick_n(1);
        check("rst_ramp_thr", 32'(throttle_out), 10);
        check("rst_ramp_state", 32'(seq_state), 0);
        check("rst_ramp_busy", 32'(busy), 0);
        reset = 1'b0;
        tick_n(61);
        check("rst_pre_done_state", 32'(seq_state), 3);
        reset = 1'b1;
        tick_n(1);
        check("rst_no_pulse", 32'(takeoff_done), 0);
        check("rst_pulse_state", 32'(seq_state), 0);
        reset = 1'b0;

        // Randomized select sequences checked by the model every cycle.
        for (int seg = 0; seg < 80; seg++) begin
            int r;
            int hold;
            logic [2:0] s;
            r = int'($urandom_range(0, 9));
            case (r)
                0:       s = 3'd0;
                1:       s = 3'd1;
                2, 3, 4: s = 3'd2;
                5, 6:    s = 3'd3;
                7:       s = 3'd4;
                default: s = 3'($urandom_range(5, 7));
            endcase
            hold = int'($urandom_range(1, 100));
            for (int c = 0; c < hold; c++) begin
                rec_data_sel      = s;
                curr_throttle_val = 8'($urandom_range(0, 255));
                reset             = ($urandom_range(0, 199) == 0);
                tick_n(1);
            end
        end
        reset = 1'b0;
        tick_n(2);
        cmp_en = 1'b0;

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
